// File: rtl/rotate_fetch_pkg.sv
// Shared types and helpers for the rotate operand fetch stage.
package rotate_fetch_pkg;

  localparam int DATA_W       = 32;
  localparam int IA_W         = DATA_W + 1;
  localparam int FETCH_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    OUT  = 2'd3
  } fetch_state_t;

  // Fully resolved command; the a/b/dest/left fields line up with the
  // operand bundle the downstream rotate stage consumes.
  typedef struct packed {
    logic [DATA_W-1:0]       a;
    logic [DATA_W-1:0]       b;
    logic [FETCH_ADDR_W-1:0] dest;
    logic                    left;
    logic                    err;
  } resolved_cmd_t;

  function automatic logic ia_is_addr(input logic [IA_W-1:0] op);
    return op[IA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] ia_value(input logic [IA_W-1:0] op);
    return op[DATA_W-1:0];
  endfunction

  // Address operand that actually needs a register file read.
  function automatic logic ia_reads(input logic [IA_W-1:0] op, input logic [DATA_W-1:0] count);
    return ia_is_addr(op) && (ia_value(op) < count);
  endfunction

  // Address operand pointing past the end of the register file.
  function automatic logic ia_bad(input logic [IA_W-1:0] op, input logic [DATA_W-1:0] count);
    return ia_is_addr(op) && !(ia_value(op) < count);
  endfunction

endpackage

// File: rtl/rotate_operand_bypass.sv
// Per-read bypass: remembers a writeback that hit the read index in the
// issue cycle and lets a capture-cycle writeback override everything.
module rotate_operand_bypass
  import rotate_fetch_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] value
);

  logic [ADDR_W-1:0] idx_reg;
  logic              hit_reg;
  logic [DATA_W-1:0] hit_data_reg;
  logic              issue_hit;
  logic              capture_hit;

  // The register file is read-before-write, so an issue-cycle write is
  // invisible in rd_data and has to be remembered here.
  assign issue_hit   = wb_valid && (wb_addr == issue_addr);
  assign capture_hit = wb_valid && (wb_addr == idx_reg);

  // Latch the read index and any issue-cycle writeback to it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_reg      <= '0;
      hit_reg      <= 1'b0;
      hit_data_reg <= '0;
    end else if (issue) begin
      idx_reg      <= issue_addr;
      hit_reg      <= issue_hit;
      hit_data_reg <= wb_data;
    end
  end

  // Newest value wins: capture-cycle writeback, then issue-cycle, then RAM.
  always_comb begin
    value = rd_data;
    if (capture_hit) begin
      value = wb_data;
    end else if (hit_reg) begin
      value = hit_data_reg;
    end
  end

endmodule

// File: rtl/rotate_operand_fetch.sv
// Resolves the two immediate-or-address operands of a rotate command
// through one synchronous register file read port and hands a complete
// command to the rotate stage.
module rotate_operand_fetch
  import rotate_fetch_pkg::*;
#(
  parameter int REG_COUNT = 64,
  parameter int ADDR_W    = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IA_W-1:0]   in_op1,
  input  logic [IA_W-1:0]   in_op2,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_left,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_left,
  output logic              out_err
);

  localparam logic [DATA_W-1:0] REG_LIMIT = REG_COUNT;

  fetch_state_t      state_reg, state_next;
  resolved_cmd_t     cmd_reg;
  logic              op2_rd_reg;
  logic [ADDR_W-1:0] op2_idx_reg;

  logic              op1_rd, op2_rd;
  logic              rd_en_next;
  logic [ADDR_W-1:0] rd_addr_next;
  logic              issue1, issue2;
  logic [DATA_W-1:0] byp1_value, byp2_value;

  assign op1_rd = ia_reads(in_op1, REG_LIMIT);
  assign op2_rd = ia_reads(in_op2, REG_LIMIT);

  // Next state and read issue; op1 is always read before op2.
  always_comb begin
    state_next   = state_reg;
    rd_en_next   = 1'b0;
    rd_addr_next = '0;
    issue1       = 1'b0;
    issue2       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (op1_rd) begin
            rd_en_next   = 1'b1;
            rd_addr_next = in_op1[ADDR_W-1:0];
            issue1       = 1'b1;
            state_next   = RD1;
          end else if (op2_rd) begin
            rd_en_next   = 1'b1;
            rd_addr_next = in_op2[ADDR_W-1:0];
            issue2       = 1'b1;
            state_next   = RD2;
          end else begin
            state_next   = OUT;
          end
        end
      end
      RD1: begin
        if (op2_rd_reg) begin
          rd_en_next   = 1'b1;
          rd_addr_next = op2_idx_reg;
          issue2       = 1'b1;
          state_next   = RD2;
        end else begin
          state_next   = OUT;
        end
      end
      RD2: state_next = OUT;
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The read strobe is combinational off IDLE, so hold it quiet in reset.
  assign rd_en   = rd_en_next & reset_n;
  assign rd_addr = reset_n ? rd_addr_next : '0;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Command latch: immediates load on accept, reads land in RD1/RD2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_reg     <= '0;
      op2_rd_reg  <= 1'b0;
      op2_idx_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            cmd_reg.a    <= ia_is_addr(in_op1) ? '0 : ia_value(in_op1);
            cmd_reg.b    <= ia_is_addr(in_op2) ? '0 : ia_value(in_op2);
            cmd_reg.dest <= in_dest;
            cmd_reg.left <= in_left;
            cmd_reg.err  <= ia_bad(in_op1, REG_LIMIT) || ia_bad(in_op2, REG_LIMIT);
            op2_rd_reg   <= op2_rd;
            op2_idx_reg  <= in_op2[ADDR_W-1:0];
          end
        end
        RD1:     cmd_reg.a <= byp1_value;
        RD2:     cmd_reg.b <= byp2_value;
        default: ;
      endcase
    end
  end

  rotate_operand_bypass #(.ADDR_W(ADDR_W)) u_byp1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .issue      (issue1),
    .issue_addr (rd_addr_next),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rd_data    (rd_data),
    .value      (byp1_value)
  );

  rotate_operand_bypass #(.ADDR_W(ADDR_W)) u_byp2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .issue      (issue2),
    .issue_addr (rd_addr_next),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rd_data    (rd_data),
    .value      (byp2_value)
  );

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == OUT);
  assign out_a     = cmd_reg.a;
  assign out_b     = cmd_reg.b;
  assign out_dest  = cmd_reg.dest;
  assign out_left  = cmd_reg.left;
  assign out_err   = cmd_reg.err;

  // Reads only happen on the way into RD1 or RD2.
  a_rd_en_legal: assert property (@(posedge clk) disable iff (!reset_n)
    rd_en |-> (((state_reg == IDLE) && ((state_next == RD1) || (state_next == RD2))) ||
               ((state_reg == RD1) && (state_next == RD2))));

  // A stalled output must not move.
  a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_a) && $stable(out_b) &&
                                   $stable(out_dest) && $stable(out_left) && $stable(out_err)));

endmodule

// File: tb/tb_rotate_operand_fetch.sv
// Directed and randomized checks of rotate_operand_fetch against a
// register-file model: an address operand takes the register value as it
// stands after the writes of its capture cycle.
module tb_rotate_operand_fetch;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_op1;
  logic [32:0] in_op2;
  logic [5:0]  in_dest;
  logic        in_left;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wb_valid;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [5:0]  out_dest;
  logic        out_left;
  logic        out_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf [64];
  logic [5:0]  rd_log [$];
  logic [5:0]  cur_i1, cur_i2;

  rotate_operand_fetch dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_dest   (in_dest),
    .in_left   (in_left),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_dest  (out_dest),
    .out_left  (out_left),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 2) return 32'h12345678;
    if (i == 3) return 32'hDEADBEEF;
    if (i == 7) return 32'd36;
    return 32'hA5000000 + 32'(i * 7919);
  endfunction

  // Read-before-write register file; reset restores known contents.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) rf[i] <= init_val(i);
    end else begin
      if (rd_en) rd_data <= rf[rd_addr];
      if (wb_valid) rf[wb_addr] <= wb_data;
    end
  end

  // Record every read strobe.
  always @(negedge clk) begin
    if (rd_en) rd_log.push_back(rd_addr);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_wb(input int k, input bit wbr, input int wbk,
                          input logic [5:0] wba, input logic [31:0] wbd);
    wb_valid = 1'b0;
    wb_addr  = 6'($urandom);
    wb_data  = $urandom;
    if (wbr) begin
      wb_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       wb_addr = cur_i1;
        1:       wb_addr = cur_i2;
        default: wb_addr = 6'($urandom);
      endcase
    end else if (k == wbk) begin
      wb_valid = 1'b1;
      wb_addr  = wba;
      wb_data  = wbd;
    end
  endtask

  task automatic run_cmd(input logic [32:0] o1, input logic [32:0] o2,
                         input logic [5:0] d, input logic l, input int hold,
                         input bit wbr, input int wbk,
                         input logic [5:0] wba, input logic [31:0] wbd);
    bit ok1, ok2;
    int lat, cap1, cap2, w, nrd;
    logic [31:0] ea, eb;
    logic ee;
    logic [5:0] exp_rd [$];
    ok1  = o1[32] && (o1[31:0] < 32'd64);
    ok2  = o2[32] && (o2[31:0] < 32'd64);
    ee   = (o1[32] && !ok1) || (o2[32] && !ok2);
    ea   = o1[32] ? 32'd0 : o1[31:0];
    eb   = o2[32] ? 32'd0 : o2[31:0];
    nrd  = int'(ok1) + int'(ok2);
    lat  = 1 + nrd;
    // Step index at which the capture cycle's writes are visible in rf.
    cap1 = ok1 ? 2 : -1;
    cap2 = ok2 ? (ok1 ? 3 : 2) : -1;
    if (ok1) exp_rd.push_back(o1[5:0]);
    if (ok2) exp_rd.push_back(o2[5:0]);
    cur_i1 = o1[5:0];
    cur_i2 = o2[5:0];
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    check("accept_ready", 64'(in_ready), 64'(1'b1));
    rd_log.delete();
    in_valid = 1'b1;
    in_op1   = o1;
    in_op2   = o2;
    in_dest  = d;
    in_left  = l;
    drive_wb(0, wbr, wbk, wba, wbd);
    for (int k = 1; k <= lat; k++) begin
      step();
      in_valid = 1'b0;
      in_op1   = 33'($urandom);
      in_op2   = 33'($urandom);
      in_dest  = 6'($urandom);
      in_left  = 1'($urandom);
      if (k == cap1) ea = rf[o1[5:0]];
      if (k == cap2) eb = rf[o2[5:0]];
      if (k < lat) begin
        check("early_valid", 64'(out_valid), 64'(1'b0));
        check("busy_ready", 64'(in_ready), 64'(1'b0));
      end
      drive_wb(k, wbr, wbk, wba, wbd);
    end
    check("out_valid", 64'(out_valid), 64'(1'b1));
    check("out_a", 64'(out_a), 64'(ea));
    check("out_b", 64'(out_b), 64'(eb));
    check("out_dest", 64'(out_dest), 64'(d));
    check("out_left", 64'(out_left), 64'(l));
    check("out_err", 64'(out_err), 64'(ee));
    check("rd_count", 64'(rd_log.size()), 64'(nrd));
    for (int i = 0; i < exp_rd.size(); i++) begin
      if (i < rd_log.size()) check("rd_addr", 64'(rd_log[i]), 64'(exp_rd[i]));
    end
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      drive_wb(lat + 1 + h, wbr, wbk, wba, wbd);
      check("hold_valid", 64'(out_valid), 64'(1'b1));
      check("hold_ready", 64'(in_ready), 64'(1'b0));
      check("hold_a", 64'(out_a), 64'(ea));
      check("hold_b", 64'(out_b), 64'(eb));
      check("hold_err", 64'(out_err), 64'(ee));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wb_valid  = 1'b0;
    check("release_ready", 64'(in_ready), 64'(1'b1));
    check("release_valid", 64'(out_valid), 64'(1'b0));
    $display("cmd op1=%h op2=%h dest=%0d left=%0d -> a=%h b=%h err=%0d lat=%0d",
             o1, o2, d, l, ea, eb, ee, lat);
  endtask

  function automatic logic [32:0] rand_op();
    int r;
    r = $urandom_range(0, 5);
    if (r < 2) return {1'b0, 32'($urandom)};
    if (r == 2) return {1'b1, 32'($urandom_range(64, 300))};
    return {1'b1, 32'($urandom_range(0, 63))};
  endfunction

  initial begin
    logic [32:0] o1, o2;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op1    = '0;
    in_op2    = '0;
    in_dest   = '0;
    in_left   = 1'b0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    out_ready = 1'b0;
    step();
    check("rst_in_ready", 64'(in_ready), 64'(1'b1));
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_rd_en", 64'(rd_en), 64'(1'b0));
    check("rst_out_a", 64'(out_a), 64'(0));
    check("rst_out_err", 64'(out_err), 64'(0));
    step();
    reset_n = 1'b1;
    step();

    // Both immediate, one address, two addresses.
    run_cmd({1'b0, 32'h80000001}, {1'b0, 32'd1}, 6'd5, 1'b1, 0, 1'b0, -1, 6'd0, 32'd0);
    run_cmd({1'b1, 32'd3}, {1'b0, 32'd8}, 6'd9, 1'b0, 0, 1'b0, -1, 6'd0, 32'd0);
    run_cmd({1'b1, 32'd2}, {1'b1, 32'd7}, 6'd1, 1'b1, 1, 1'b0, -1, 6'd0, 32'd0);
    // Issue-cycle writeback to reg3 must be bypassed.
    run_cmd({1'b1, 32'd3}, {1'b0, 32'd8}, 6'd4, 1'b0, 0, 1'b0, 0, 6'd3, 32'hCAFEF00D);
    // Capture-cycle writeback on op2.
    run_cmd({1'b1, 32'd2}, {1'b1, 32'd7}, 6'd4, 1'b0, 0, 1'b0, 2, 6'd7, 32'd99);
    // Writeback during OUT must not disturb the held operands.
    run_cmd({1'b1, 32'd3}, {1'b0, 32'd8}, 6'd6, 1'b1, 2, 1'b0, 2, 6'd3, 32'h11111111);
    // Out of range op1 with a long stall.
    run_cmd({1'b1, 32'd64}, {1'b0, 32'd4}, 6'd2, 1'b0, 5, 1'b0, -1, 6'd0, 32'd0);
    // Same index on both operands.
    run_cmd({1'b1, 32'd7}, {1'b1, 32'd7}, 6'd7, 1'b1, 0, 1'b0, 2, 6'd7, 32'h0BADF00D);

    // Reset while in RD2: everything back to reset values at once.
    in_valid = 1'b1;
    in_op1   = {1'b1, 32'd2};
    in_op2   = {1'b1, 32'd7};
    in_dest  = 6'd33;
    in_left  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(1'b1));
    check("mid_rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("mid_rst_rd_en", 64'(rd_en), 64'(1'b0));
    check("mid_rst_rd_addr", 64'(rd_addr), 64'(0));
    check("mid_rst_out_a", 64'(out_a), 64'(0));
    check("mid_rst_out_b", 64'(out_b), 64'(0));
    check("mid_rst_out_dest", 64'(out_dest), 64'(0));
    check("mid_rst_out_left", 64'(out_left), 64'(0));
    check("mid_rst_out_err", 64'(out_err), 64'(0));
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_valid", 64'(out_valid), 64'(1'b0));
    end
    run_cmd({1'b1, 32'd3}, {1'b1, 32'd2}, 6'd12, 1'b0, 0, 1'b0, -1, 6'd0, 32'd0);

    // Randomized commands with random writeback traffic and stalls.
    for (int n = 0; n < 40; n++) begin
      o1 = rand_op();
      o2 = rand_op();
      if (o1[32] && $urandom_range(0, 3) == 0) o2 = o1;
      run_cmd(o1, o2, 6'($urandom), 1'($urandom), $urandom_range(0, 3),
              1'b1, -1, 6'd0, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
